sram1rw_arbiter: RTL

- Shares one single-port 1RW SRAM macro (64x32, active-low CSB/WEB/OEB, clocked on its rising CE edge, read data held on O until the next read) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready read-response channel.
- Round-robin arbitration, at most one SRAM access per cycle.
- After reset, an optional sweep clears every SRAM word before requests are accepted.
- Sits between cache/queue logic and the macro; the macro's CE is tied to `clock` at the parent level.

---
 rtl/sram1rw_arbiter_pkg.sv | 38 +++
 rtl/sram1rw_arbiter_if.sv | 31 +++
 rtl/sram_rsp_slot.sv | 44 ++++
 rtl/sram1rw_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sram1rw_arbiter_pkg.sv
// Shared types for the single-port SRAM arbiter.
//   state_e     : controller state (clear sweep, normal arbitration)
//   sram_op_e   : access issued to the macro in the current cycle
//   sram_ctrl_t : active-low csb/web/oeb triple derived from an op
package sram1rw_arbiter_pkg;

  localparam int unsigned NREQ = 2;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    OpIdle,
    OpRd,
    OpWr
  } sram_op_e;

  typedef struct packed {
    logic csb;
    logic web;
    logic oeb;
  } sram_ctrl_t;

  // Map an access type onto the macro's active-low control pins.
  function automatic sram_ctrl_t sram_op_ctrl(sram_op_e op);
    sram_ctrl_t c;
    c = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};
    case (op)
      OpRd:    c = '{csb: 1'b0, web: 1'b1, oeb: 1'b0};
      OpWr:    c = '{csb: 1'b0, web: 1'b0, oeb: 1'b1};
      default: c = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram1rw_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-requester request and read-response
// valid/ready channels, packed so that bit/slice k belongs to requester k.
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side
interface sram1rw_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) ();
  import sram1rw_arbiter_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ*DATA_W-1:0] rsp_rdata;
  logic                   init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );

endinterface

// File: rtl/sram_rsp_slot.sv
// Single-entry read-response holding register.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i/data_i : capture data_i at the end of this cycle
//   valid_o/data_o: held response, stable until ready_i is seen with valid_o
module sram_rsp_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    // The arbiter never loads a full slot that is not draining this cycle.
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sram1rw_arbiter.sv
// Round-robin arbiter sharing one 1RW SRAM macro between two requesters, with an
// optional post-reset clear sweep.
//   clock, reset_n : clock (also the macro CE), synchronous active-low reset
//   bus            : requester request/response channels and init_done
//   sram_*         : macro pins; controls are combinational so the access happens at
//                    the rising edge that closes the current cycle
module sram1rw_arbiter
  import sram1rw_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 6,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 64,  // must equal 2**ADDR_W
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  sram1rw_arbiter_if.slave  bus,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rr_q, rr_d;
  logic [NREQ-1:0]   inflight_q, inflight_d;
  logic              init_done_q, init_done_d;

  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant;
  logic              gidx;
  logic [NREQ-1:0]   slot_valid;
  logic [DATA_W-1:0] slot_data [NREQ];
  sram_op_e          op;
  sram_ctrl_t        ctrl;

  // A read may only issue when its response slot is guaranteed free at capture time.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = bus.req_valid[k] &
                (bus.req_we[k] | (~inflight_q[k] & (~slot_valid[k] | bus.rsp_ready[k])));
    end
  end

  always_comb begin
    grant = '0;
    if (reset_n && (state_q == StRun)) begin
      if (&elig) grant[rr_q] = 1'b1;
      else       grant = elig;
    end
    gidx = grant[1];
  end

  always_comb begin
    op     = OpIdle;
    sram_a = '0;
    sram_i = '0;
    if (reset_n) begin
      if (state_q == StInit) begin
        op     = OpWr;
        sram_a = clr_cnt_q;
        sram_i = CLEAR_VALUE;
      end else if (|grant) begin
        op     = bus.req_we[gidx] ? OpWr : OpRd;
        sram_a = bus.req_addr[gidx*ADDR_W +: ADDR_W];
        sram_i = bus.req_wdata[gidx*DATA_W +: DATA_W];
      end
    end
    ctrl     = sram_op_ctrl(op);
    sram_csb = ctrl.csb;
    sram_web = ctrl.web;
    sram_oeb = ctrl.oeb;
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    rr_d        = rr_q;
    inflight_d  = grant & ~bus.req_we;
    if (state_q == StInit) begin
      // Counter parks on the last address instead of wrapping.
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d     = StRun;
        init_done_d = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
    if (|grant) rr_d = ~gidx;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= CLEAR_ON_RESET ? StInit : StRun;
      clr_cnt_q   <= '0;
      rr_q        <= 1'b0;
      inflight_q  <= '0;
      init_done_q <= ~CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_q        <= rr_d;
      inflight_q  <= inflight_d;
      init_done_q <= init_done_d;
    end
  end

  // sram_o is valid the cycle after the read edge, which is when inflight is set.
  for (genvar k = 0; k < NREQ; k++) begin : g_slot
    sram_rsp_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .load_i  (inflight_q[k]),
      .data_i  (sram_o),
      .ready_i (bus.rsp_ready[k]),
      .valid_o (slot_valid[k]),
      .data_o  (slot_data[k])
    );
  end

  always_comb begin
    bus.rsp_rdata = '0;
    for (int k = 0; k < NREQ; k++) bus.rsp_rdata[k*DATA_W +: DATA_W] = slot_data[k];
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = slot_valid;
  assign bus.init_done = init_done_q;

endmodule
